// File: rtl/shx_pkg.sv
// shx_pkg: shared types and helpers for the shx_sipo deserialiser.
// The frame length covers the data bits plus an optional parity bit.
package shx_pkg;

    localparam int SHX_WIDTH_MAX = 32;

    // Wide enough for SHX_WIDTH_MAX data bits plus one parity bit
    typedef logic [$clog2(SHX_WIDTH_MAX + 2)-1:0] frame_len_t;

    function automatic int cnt_w(input int frame);
        return $clog2(frame);
    endfunction

endpackage

// File: rtl/shx_bitcnt.sv
// shx_bitcnt: modulo-FRAME bit counter with EN, SYNC and RST.
// LAST strobes in the cycle that accepts the final bit of a frame.
module shx_bitcnt
    import shx_pkg::*;
#(
    parameter int FRAME = 8,
    parameter int CW    = cnt_w(FRAME)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          SYNC,
    output logic [CW-1:0] CNT,
    output logic          LAST
);

    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // SYNC restarts framing and cannot complete a frame
    assign LAST = EN && !SYNC && (cnt_q == CNT_MAX);
    assign CNT  = cnt_q;

    // Next count: SYNC restarts, EN advances, LAST wraps
    always_comb begin
        cnt_d = cnt_q;
        if (SYNC) begin
            cnt_d = EN ? CW'(1) : '0;
        end else if (EN) begin
            cnt_d = LAST ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shx_sipo.sv
// shx_sipo: serial-in parallel-out deserialiser with VALID/ACK holding
// register and sticky overrun. SHX_SIPO_PARITY_EN adds even parity/PERR.
module shx_sipo
    import shx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIN,
    input  logic             SYNC,
    input  logic             ACK,
    input  logic             CLR_OVR,
    output logic             VALID,
    output logic [WIDTH-1:0] DOUT,
    output logic             BUSY,
`ifdef SHX_SIPO_PARITY_EN
    output logic             OVR,
    output logic             PERR
`else
    output logic             OVR
`endif
);

`ifdef SHX_SIPO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    localparam frame_len_t FRAME = frame_len_t'(WIDTH + PAR);
    localparam int         CW    = cnt_w(int'(FRAME));

    logic [CW-1:0]    cnt;
    logic             last;
    logic             shift_en;
    logic             accept;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] word;

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             ovr_q;

    shx_bitcnt #(
        .FRAME (int'(FRAME)),
        .CW    (CW)
    ) u_bitcnt (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .SYNC (SYNC),
        .CNT  (cnt),
        .LAST (last)
    );

    // Bit-order selection for the shift register
    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], DIN};
        end else begin
            sr_shift = {DIN, sr_q[WIDTH-1:1]};
        end
    end

`ifdef SHX_SIPO_PARITY_EN
    // Parity bit is consumed by the check, never shifted in
    assign shift_en = EN && !last;
    assign word     = sr_q;
`else
    assign shift_en = EN;
    assign word     = sr_shift;
`endif

    // A completed word may load when the slot is free or being freed
    assign accept = !valid_q || ACK;

    // Shift register; SYNC needs no clearing since stale bits age out
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q <= '0;
        end else if (shift_en) begin
            sr_q <= sr_shift;
        end
    end

    // Holding register and VALID handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (last) begin
            if (accept) begin
                dout_q  <= word;
                valid_q <= 1'b1;
            end
        end else if (ACK) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky overrun: a dropped word beats a simultaneous clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovr_q <= 1'b0;
        end else if (last && !accept) begin
            ovr_q <= 1'b1;
        end else if (CLR_OVR) begin
            ovr_q <= 1'b0;
        end
    end

`ifdef SHX_SIPO_PARITY_EN
    logic perr_q;

    // PERR loads together with DOUT and holds on a dropped word
    always_ff @(posedge CLK) begin
        if (RST) begin
            perr_q <= 1'b0;
        end else if (last && accept) begin
            perr_q <= (^sr_q) ^ DIN;
        end
    end

    assign PERR = perr_q;
`endif

    assign VALID = valid_q;
    assign DOUT  = dout_q;
    assign BUSY  = (cnt != '0);
    assign OVR   = ovr_q;

endmodule
